test_port_monitor: RTL and testbench
====================================

# test_port_monitor

Synthesizable, parametrised result checker and cache-traffic monitor for the L2-cache test harness. It snoops the core's data-memory write bus for stores to a dedicated test port, starts on a begin symbol and compares each later test-port store against a programmable expected-value table. It reports error count, run duration, finish and timeout. It also keeps per-channel read, write and stall statistics for NUM_CH cache ports.

## Interface
- ADDR_W, 30, word-address width of the snooped bus
- DATA_W, 32, data width (multiple of 8)
- TEST_PORT, 30'h3FF, word address of the test port
- BEGIN_SYM, 32'h00000168, start symbol (readable byte order)
- MAX_CHECK, 16, depth of the expected-value table
- NUM_CH, 2, number of monitored cache channels
- CNT_W, 32, width of the duration and statistics counters
- BYTE_SWAP, 1, 1 = reverse the bytes of data before any compare (little-endian bus)
- TIMEOUT, 32'd1_000_000, CHECK-state cycle limit
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  ADDR_W  snooped write address
- data  in  DATA_W  snooped write data
- wen  in  1  snooped write enable
- exp_wen  in  1  expected-table write strobe
- exp_idx  in  clog2(MAX_CHECK)  table index
- exp_data  in  DATA_W  expected value (readable byte order)
- exp_num  in  clog2(MAX_CHECK+1)  number of checks; latched at begin
- ch_ren, ch_wen, ch_stall  in  NUM_CH each  per-channel cache request and stall
- error_num  out  8  mismatch count; saturates at 255
- duration  out  CNT_W  cycles spent in CHECK
- finish  out  1  high while in DONE
- timeout  out  1  the run ended by TIMEOUT
- first_err_valid  out  1  at least one mismatch was recorded
- first_err_idx  out  clog2(MAX_CHECK)  index of the first mismatch
- ren_cnt, wen_cnt, stall_cnt  out  NUM_CH*CNT_W  per-channel counters, channel 0 in the LSBs

## Operation
- dm = data byte-reversed if BYTE_SWAP, else data.
- Accepted write = wen & (addr==TEST_PORT) & !wen_q, where wen_q is wen registered. A multi-cycle wen caused by a D-cache stall counts once.
- FSM states: IDLE, CHECK, DONE.
- IDLE -> CHECK: on an accepted write with dm==BEGIN_SYM. The same edge sets error_num=0, duration=0 and idx=0, clears first_err_valid, and latches exp_num into num_q.
  - If exp_num==0, go to DONE instead, with error_num=0.
  - An accepted write with any other value in IDLE is ignored.
- CHECK:
  - duration increments every cycle, saturating at all-ones.
  - On an accepted write: compare dm with exp_mem[idx]. On a mismatch, increment error_num (saturating at 255). On the first mismatch also set first_err_valid=1 and first_err_idx=idx. Then idx increments.
  - When the accepted write is for idx==num_q-1, go to DONE on that same edge.
  - When duration==TIMEOUT-1 with no completing write, go to DONE and set timeout=1. Unchecked entries are not counted as errors.
- DONE: all outputs frozen until reset. Further writes and exp_wen are ignored.
- Expected table: exp_mem[exp_idx] <= exp_data on exp_wen in IDLE only. exp_wen in CHECK or DONE is ignored. exp_idx >= MAX_CHECK is ignored. exp_num > MAX_CHECK is clamped to MAX_CHECK.
- Per-channel stats, updated in IDLE and CHECK, frozen in DONE:
  - busy flag b. If b: clear b when !stall.
  - Else if ren: ren_cnt++, b = stall.
  - Else if wen: wen_cnt++, b = stall. ren has priority when ren and wen are both high.
  - stall_cnt++ on every cycle with stall high.
  - All stat counters saturate.

## Timing
- Reset values: state=IDLE, error_num=8'hFF (run not started), duration=0, finish=0, timeout=0, first_err_valid=0, first_err_idx=0, all counters 0, busy flags 0, wen_q=0. Table contents are not reset.
- All outputs are registered. finish rises the cycle after the edge that enters DONE.
- If the begin is accepted at edge 0 and the final check write at edge n, then duration=n.
- Asserting rst mid-run returns to IDLE immediately. A run in progress is discarded.
- Compare latency is 0: the check uses the idx value current at the accepting edge.

## Test plan
- Program exp={0,1,1,1,1,0,32'hFFFFFD5D}, exp_num=7 -> write 32'h68010000 to 0x3FF, then the seven values little-endian, one per 5 cycles -> finish=1, error_num=0, duration=35, first_err_valid=0.
- Same run with the 3rd value written as 2 -> error_num=1, first_err_idx=2, finish=1.
- Hold wen high for 4 cycles on one test-port write -> counted once. A write to 0x3FE is never counted.
- Set TIMEOUT=100 and send only 3 of 7 values -> DONE at duration=99, timeout=1, error_num=0.
- Ch0: ren with stall for 3 cycles, then wen without stall; ch1 idle -> ren_cnt[0]=1, wen_cnt[0]=1, stall_cnt[0]=3, all ch1 counters 0.
- Assert rst mid-CHECK, then apply a begin with exp_num=0 -> error_num=8'hFF during reset; after the begin, finish=1 and error_num=0.

Source files
------------

// File: rtl/test_port_monitor.sv
// Snoops test-port stores, checks them against a programmable expected table,
// and keeps per-channel cache read/write/stall statistics. All outputs registered.
module test_port_monitor #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT = 'h3FF,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 'h00000168,
  parameter int                MAX_CHECK = 16,
  parameter int                NUM_CH    = 2,
  parameter int                CNT_W     = 32,
  parameter bit                BYTE_SWAP = 1'b1,
  parameter int unsigned       TIMEOUT   = 32'd1_000_000,
  localparam int IDX_W = (MAX_CHECK > 1) ? $clog2(MAX_CHECK) : 1,
  localparam int NUM_W = $clog2(MAX_CHECK + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       data,
  input  logic                    wen,
  input  logic                    exp_wen,
  input  logic [IDX_W-1:0]        exp_idx,
  input  logic [DATA_W-1:0]       exp_data,
  input  logic [NUM_W-1:0]        exp_num,
  input  logic [NUM_CH-1:0]       ch_ren,
  input  logic [NUM_CH-1:0]       ch_wen,
  input  logic [NUM_CH-1:0]       ch_stall,
  output logic [7:0]              error_num,
  output logic [CNT_W-1:0]        duration,
  output logic                    finish,
  output logic                    timeout,
  output logic                    first_err_valid,
  output logic [IDX_W-1:0]        first_err_idx,
  output logic [NUM_CH*CNT_W-1:0] ren_cnt,
  output logic [NUM_CH*CNT_W-1:0] wen_cnt,
  output logic [NUM_CH*CNT_W-1:0] stall_cnt
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic               wen_q;
  logic [7:0]         err_q, err_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic               finish_q, finish_d;
  logic               timeout_q, timeout_d;
  logic               fev_q, fev_d;
  logic [IDX_W-1:0]   fei_q, fei_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [DATA_W-1:0]  exp_mem [MAX_CHECK];
  logic [DATA_W-1:0]  dm;
  logic [DATA_W-1:0]  exp_rd;
  logic [NUM_W-1:0]   num_clamp;
  logic               acc;

  always_comb begin
    dm = data;
    if (BYTE_SWAP) begin
      for (int b = 0; b < NB; b++) dm[8*b +: 8] = data[DATA_W-8-8*b +: 8];
    end
  end

  // A stalled store holds wen for several cycles; only its first cycle counts.
  assign acc       = wen && (addr == TEST_PORT) && !wen_q;
  assign exp_rd    = exp_mem[idx_q];
  assign num_clamp = (exp_num > NUM_W'(MAX_CHECK)) ? NUM_W'(MAX_CHECK) : exp_num;

  always_ff @(posedge clk) begin
    if (exp_wen && (state_q == IDLE) && (32'(exp_idx) < MAX_CHECK))
      exp_mem[exp_idx] <= exp_data;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    dur_d     = dur_q;
    timeout_d = timeout_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    idx_d     = idx_q;
    num_d     = num_q;
    case (state_q)
      IDLE: begin
        if (acc && (dm == BEGIN_SYM)) begin
          err_d     = 8'd0;
          dur_d     = '0;
          idx_d     = '0;
          fev_d     = 1'b0;
          timeout_d = 1'b0;
          num_d     = num_clamp;
          state_d   = (num_clamp == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (dur_q != '1) dur_d = dur_q + CNT_W'(1);
        if (acc) begin
          if (dm != exp_rd) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (NUM_W'(idx_q) == num_q - NUM_W'(1)) state_d = DONE;
        end
        // A completing write on the same edge wins over the timeout.
        if ((state_d == CHECK) && (dur_q == CNT_W'(TIMEOUT - 1))) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          dur_d     = dur_q;
        end
      end
      default: ;
    endcase
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      err_q     <= 8'hFF;
      dur_q     <= '0;
      finish_q  <= 1'b0;
      timeout_q <= 1'b0;
      fev_q     <= 1'b0;
      fei_q     <= '0;
      idx_q     <= '0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen;
      err_q     <= err_d;
      dur_q     <= dur_d;
      finish_q  <= finish_d;
      timeout_q <= timeout_d;
      fev_q     <= fev_d;
      fei_q     <= fei_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
    end
  end

  assign error_num       = err_q;
  assign duration        = dur_q;
  assign finish          = finish_q;
  assign timeout         = timeout_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             busy_q;
    logic [CNT_W-1:0] ren_q, wen_cq, stall_q;

    // A stalled request keeps the channel busy so it is counted only once.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        busy_q  <= 1'b0;
        ren_q   <= '0;
        wen_cq  <= '0;
        stall_q <= '0;
      end else if (state_q != DONE) begin
        if (busy_q) begin
          if (!ch_stall[c]) busy_q <= 1'b0;
        end else if (ch_ren[c]) begin
          if (ren_q != '1) ren_q <= ren_q + CNT_W'(1);
          busy_q <= ch_stall[c];
        end else if (ch_wen[c]) begin
          if (wen_cq != '1) wen_cq <= wen_cq + CNT_W'(1);
          busy_q <= ch_stall[c];
        end
        if (ch_stall[c] && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      end
    end

    assign ren_cnt[c*CNT_W +: CNT_W]   = ren_q;
    assign wen_cnt[c*CNT_W +: CNT_W]   = wen_cq;
    assign stall_cnt[c*CNT_W +: CNT_W] = stall_q;
  end

endmodule

// File: tb/tb_test_port_monitor.sv
// Directed bench for test_port_monitor: checked runs, errors, held writes, timeout,
// mid-run reset and per-channel statistics.
module tb_test_port_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        exp_wen;
  logic [3:0]  exp_idx;
  logic [31:0] exp_data;
  logic [4:0]  exp_num;
  logic [1:0]  ch_ren, ch_wen, ch_stall;
  logic [7:0]  error_num;
  logic [31:0] duration;
  logic        finish, timeout, first_err_valid;
  logic [3:0]  first_err_idx;
  logic [63:0] ren_cnt, wen_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_tab [7];

  localparam logic [31:0] BEGIN_LE = 32'h68010000;

  test_port_monitor #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_wen(exp_wen), .exp_idx(exp_idx), .exp_data(exp_data), .exp_num(exp_num),
    .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_stall(ch_stall),
    .error_num(error_num), .duration(duration), .finish(finish), .timeout(timeout),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .ren_cnt(ren_cnt), .wen_cnt(wen_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [29:0] a, input logic [31:0] d, input int gap);
    addr = a;
    data = d;
    wen  = 1'b1;
    tick();
    wen  = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    exp_tab = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'hFFFFFD5D};
    rst = 1'b1; addr = '0; data = '0; wen = 1'b0;
    exp_wen = 1'b0; exp_idx = '0; exp_data = '0; exp_num = 5'd7;
    ch_ren = '0; ch_wen = '0; ch_stall = '0;
    #2 rst = 1'b0;
    #2;
    chk("rst_error_num", error_num, 8'hFF);
    chk("rst_duration", duration, 0);
    chk("rst_finish", finish, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fev", first_err_valid, 0);
    chk("rst_fei", first_err_idx, 0);
    chk("rst_ren_cnt", ren_cnt, 0);
    tick();
    rst = 1'b1;
    tick();

    // Channel statistics: stalled read, then a write offered while still busy and after.
    ch_ren = 2'b01; ch_stall = 2'b01;
    repeat (3) tick();
    ch_ren = 2'b00; ch_stall = 2'b00; ch_wen = 2'b01;
    tick();
    tick();
    ch_wen = 2'b00;
    tick();
    chk("stat_ren", ren_cnt, {32'd0, 32'd1});
    chk("stat_wen", wen_cnt, {32'd0, 32'd1});
    chk("stat_stall", stall_cnt, {32'd0, 32'd3});

    for (int i = 0; i < 7; i++) begin
      exp_wen = 1'b1; exp_idx = 4'(i); exp_data = exp_tab[i];
      tick();
    end
    exp_wen = 1'b0;

    // Clean run: seven matching values, one every 5 cycles.
    send(30'h3FF, BEGIN_LE, 5);
    chk("run1_err_cleared", error_num, 0);
    for (int i = 0; i < 7; i++) begin
      send(30'h3FF, bswap(exp_tab[i]), 5);
      if (i == 5) chk("run1_not_done", finish, 0);
    end
    chk("run1_finish", finish, 1);
    chk("run1_error_num", error_num, 0);
    chk("run1_duration", duration, 35);
    chk("run1_fev", first_err_valid, 0);
    chk("run1_timeout", timeout, 0);
    send(30'h3FF, BEGIN_LE, 2);
    send(30'h3FF, 32'hDEADBEEF, 2);
    chk("done_frozen_err", error_num, 0);
    chk("done_frozen_dur", duration, 35);

    // Third value wrong.
    do_reset();
    chk("run2_rst_err", error_num, 8'hFF);
    send(30'h3FF, BEGIN_LE, 5);
    for (int i = 0; i < 7; i++)
      send(30'h3FF, (i == 2) ? bswap(32'd2) : bswap(exp_tab[i]), 5);
    chk("run2_error_num", error_num, 1);
    chk("run2_fei", first_err_idx, 2);
    chk("run2_fev", first_err_valid, 1);
    chk("run2_finish", finish, 1);

    // Write to the wrong address, then one store held for 4 cycles.
    do_reset();
    send(30'h3FF, BEGIN_LE, 5);
    send(30'h3FE, 32'hDEADBEEF, 5);
    addr = 30'h3FF; data = bswap(exp_tab[0]); wen = 1'b1;
    repeat (4) tick();
    wen = 1'b0;
    tick();
    chk("hold_err", error_num, 0);
    chk("hold_not_done", finish, 0);
    for (int i = 1; i < 7; i++) send(30'h3FF, bswap(exp_tab[i]), 2);
    chk("hold_finish", finish, 1);
    chk("hold_err_end", error_num, 0);

    // Timeout after 3 of 7 values.
    do_reset();
    send(30'h3FF, BEGIN_LE, 5);
    for (int i = 0; i < 3; i++) send(30'h3FF, bswap(exp_tab[i]), 5);
    for (int k = 0; k < 150 && !finish; k++) tick();
    chk("to_finish", finish, 1);
    chk("to_timeout", timeout, 1);
    chk("to_duration", duration, 99);
    chk("to_error_num", error_num, 0);

    // Non-begin in IDLE ignored; reset mid-run; begin with zero checks.
    do_reset();
    send(30'h3FF, 32'h12345678, 2);
    chk("idle_ignore_finish", finish, 0);
    chk("idle_ignore_err", error_num, 8'hFF);
    send(30'h3FF, BEGIN_LE, 5);
    send(30'h3FF, bswap(exp_tab[0]), 5);
    send(30'h3FF, bswap(32'd7), 5);
    rst = 1'b0;
    #1;
    chk("midrst_err", error_num, 8'hFF);
    chk("midrst_finish", finish, 0);
    chk("midrst_dur", duration, 0);
    tick();
    rst = 1'b1;
    tick();
    exp_num = 5'd0;
    send(30'h3FF, BEGIN_LE, 2);
    chk("zero_finish", finish, 1);
    chk("zero_err", error_num, 0);
    chk("zero_dur", duration, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
